// File: rtl/alu_norm_pkg.sv
// Shared types and helpers for the ALU normalisation path.
// Holds the shift opcode and element-width encodings plus a width lookup.
package alu_norm_pkg;

  // Shift operation carried alongside each operand beat.
  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROR = 2'd3
  } shift_op_e;

  // Selected element width; the top encoding is reserved.
  typedef enum logic [1:0] {
    SEW8     = 2'd0,
    SEW16    = 2'd1,
    SEW32    = 2'd2,
    SEW_RSVD = 2'd3
  } sew_e;

  // log2 of the widest element; this is the number of log-shifter stages.
  localparam int unsigned MAX_SEW_LOG2 = 32'd5;

  // Element width in bits for a SEW encoding; 0 for the reserved code.
  function automatic int unsigned sew_bits(input sew_e sew);
    case (sew)
      SEW8:    return 32'd8;
      SEW16:   return 32'd16;
      SEW32:   return 32'd32;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/vshift_sew_core.sv
// Combinational packed-element shifter.
// Each lane is split into independent elements of the selected width. A
// log-shifter applies shifts of 1, 2, 4, ... per element; every stage only
// sources bits from inside the same element, so nothing crosses an element
// boundary. Only the low log2(SEW) bits of each element's shift amount are
// used because stages at or above the element width are skipped.
module vshift_sew_core
  import alu_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] shift,
  input  shift_op_e             op,
  input  sew_e                  sew,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  // Log-shift of every element of width w. w is a constant at each call
  // site, so all index arithmetic folds to fixed wiring.
  function automatic logic [DATA_WIDTH-1:0] log_shift(
    input logic [DATA_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0] amt,
    input shift_op_e             op_sel,
    input int unsigned           w
  );
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] nxt;
    int unsigned           step;
    int unsigned           base;
    int unsigned           offs;
    int unsigned           idx_l;
    int unsigned           idx_r;
    int unsigned           idx_rot;
    cur     = src;
    nxt     = src;
    step    = 32'd0;
    base    = 32'd0;
    offs    = 32'd0;
    idx_l   = 32'd0;
    idx_r   = 32'd0;
    idx_rot = 32'd0;
    for (int unsigned s = 32'd0; s < MAX_SEW_LOG2; s++) begin
      step = 32'd1 << s;
      if (step < w) begin
        for (int unsigned j = 32'd0; j < DATA_WIDTH; j++) begin
          offs    = j % w;
          base    = j - offs;
          // Out-of-element sources fall back to j; the fill value is chosen below.
          idx_l   = (offs >= step) ? (j - step) : j;
          idx_r   = ((offs + step) < w) ? (j + step) : j;
          idx_rot = base + ((offs + step) % w);
          if (amt[base + s]) begin
            case (op_sel)
              SH_SLL:  nxt[j] = (offs >= step) ? cur[idx_l] : 1'b0;
              SH_SRL:  nxt[j] = ((offs + step) < w) ? cur[idx_r] : 1'b0;
              SH_SRA:  nxt[j] = ((offs + step) < w) ? cur[idx_r] : cur[base + w - 32'd1];
              SH_ROR:  nxt[j] = cur[idx_rot];
              default: nxt[j] = cur[j];
            endcase
          end else begin
            nxt[j] = cur[j];
          end
        end
        cur = nxt;
      end else begin
        nxt = cur;
      end
    end
    return cur;
  endfunction

  // Select the per-width shifter; the reserved width passes the operand through and flags it.
  always_comb begin
    result  = a;
    illegal = 1'b0;
    case (sew)
      SEW8: begin
        result  = log_shift(a, shift, op, sew_bits(SEW8));
        illegal = 1'b0;
      end
      SEW16: begin
        result  = log_shift(a, shift, op, sew_bits(SEW16));
        illegal = 1'b0;
      end
      SEW32: begin
        result  = log_shift(a, shift, op, sew_bits(SEW32));
        illegal = 1'b0;
      end
      default: begin
        result  = a;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_vshift_pipe.sv
// Pipelined, SEW-aware vector-lane shifter.
// The combinational shift core feeds a chain of elastic register stages with
// valid/ready on both sides. A stage advances when it is empty or when the
// stage after it (or the consumer, for the last stage) takes its beat, so
// bubbles collapse and a full pipe accepts and emits in the same cycle.
// flush_i empties the pipe on the next edge and overrides every load.
module alu_vshift_pipe
  import alu_norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [1:0]            sew_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] shift_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  illegal_o
);

  localparam int unsigned LAST = PIPE_STAGES - 32'd1;

  logic [DATA_WIDTH-1:0]  core_result_s;
  logic                   core_illegal_s;
  logic [PIPE_STAGES:0]   adv_s;
  logic [PIPE_STAGES-1:0] valid_r;
  logic [PIPE_STAGES-1:0] illegal_r;
  logic [DATA_WIDTH-1:0]  result_r [PIPE_STAGES];

  vshift_sew_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .a       (a_i),
    .shift   (shift_i),
    .op      (shift_op_e'(op_i)),
    .sew     (sew_e'(sew_i)),
    .result  (core_result_s),
    .illegal (core_illegal_s)
  );

  // Advance enables, resolved from the consumer back towards the input.
  always_comb begin
    adv_s              = {(PIPE_STAGES + 1){1'b0}};
    adv_s[PIPE_STAGES] = out_ready_i;
    for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
      adv_s[k] = ~valid_r[k] | adv_s[k + 1];
    end
  end

  assign in_ready_o = adv_s[0];

  // Stage registers: flush clears occupancy; datapath bits only load with a valid beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r   <= {PIPE_STAGES{1'b0}};
      illegal_r <= {PIPE_STAGES{1'b0}};
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        result_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (flush_i) begin
      valid_r <= {PIPE_STAGES{1'b0}};
    end else begin
      if (adv_s[0]) begin
        valid_r[0] <= in_valid_i;
        if (in_valid_i) begin
          result_r[0]  <= core_result_s;
          illegal_r[0] <= core_illegal_s;
        end
      end
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        if (adv_s[k]) begin
          valid_r[k] <= valid_r[k - 1];
          if (valid_r[k - 1]) begin
            result_r[k]  <= result_r[k - 1];
            illegal_r[k] <= illegal_r[k - 1];
          end
        end
      end
    end
  end

  assign out_valid_o = valid_r[LAST];
  assign result_o    = result_r[LAST];
  assign illegal_o   = illegal_r[LAST];

endmodule

// File: tb/tb_alu_vshift_pipe.sv
// Directed self-checking bench for alu_vshift_pipe (32-bit lane, 2 stages).
module tb_alu_vshift_pipe;

  localparam int P  = 2;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_ni;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [1:0]    op_i;
  logic [1:0]    sew_i;
  logic [DW-1:0] a_i;
  logic [DW-1:0] shift_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] result_o;
  logic          illegal_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BP_A   [6] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033,
                                         32'h8000_0044, 32'h0F00_0055, 32'h0000_0066};
  localparam logic [31:0] BP_EXP [6] = '{32'h0000_0110, 32'h0000_0220, 32'h0000_0330,
                                         32'h0000_0440, 32'hF000_0550, 32'h0000_0660};

  alu_vshift_pipe #(
    .DATA_WIDTH  (DW),
    .PIPE_STAGES (P)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .sew_i       (sew_i),
    .a_i         (a_i),
    .shift_i     (shift_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .illegal_o   (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    rst_ni = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_i = 2'd0; sew_i = 2'd0; a_i = '0; shift_i = '0;
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid_o); end
    total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result: got=%h exp=0", result_o); end
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL reset_illegal: got=%b exp=0", illegal_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready_o); end
  endtask

  task automatic test_single(input string name, input logic [1:0] op, input logic [1:0] sew,
                             input logic [31:0] a, input logic [31:0] sh,
                             input logic [31:0] exp, input logic exp_ill);
    int lat;
    out_ready_i = 1'b1; in_valid_i = 1'b1; op_i = op; sew_i = sew; a_i = a; shift_i = sh;
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got=%b exp=1", name, in_ready_o); end
    @(posedge clk_i);
    lat = 1;
    #1;
    in_valid_i = 1'b0;
    while (out_valid_o !== 1'b1 && lat < 10) begin
      @(posedge clk_i); #1; lat++;
    end
    total++; if (lat != P) begin bad++; $display("FAIL %s_latency: got=%0d exp=%0d", name, lat, P); end
    total++; if (result_o !== exp) begin bad++; $display("FAIL %s_result: got=%h exp=%h", name, result_o, exp); end
    total++; if (illegal_o !== exp_ill) begin bad++; $display("FAIL %s_illegal: got=%b exp=%b", name, illegal_o, exp_ill); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic acc;
    logic held_ok = 1'b0;
    logic [31:0] held = '0;
    logic seen = 1'b0;
    op_i = 2'd0; sew_i = 2'd2; shift_i = 32'h0000_0004;
    while (got < 6 && cyc < 60) begin
      in_valid_i  = (sent < 6);
      a_i         = BP_A[(sent < 6) ? sent : 5];
      out_ready_i = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
      #1;
      if (!out_ready_i) begin
        total++;
        if (in_ready_o !== 1'b0 || sent != P) begin
          bad++; $display("FAIL bp_stall_ready: in_ready=%b accepted=%0d exp in_ready=0 accepted=%0d", in_ready_o, sent, P);
        end
        if (held_ok) begin
          total++;
          if (out_valid_o !== 1'b1 || result_o !== held) begin
            bad++; $display("FAIL bp_hold: valid=%b result=%h exp valid=1 result=%h", out_valid_o, result_o, held);
          end
        end else begin
          held    = result_o;
          held_ok = 1'b1;
        end
      end
      if (out_valid_o === 1'b1 && out_ready_i) begin
        total++;
        if (result_o !== BP_EXP[got]) begin
          bad++; $display("FAIL bp_order[%0d]: got=%h exp=%h", got, result_o, BP_EXP[got]);
        end
        got++;
      end
      acc = in_valid_i && in_ready_o;
      @(posedge clk_i); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid_i = 1'b0;
    total++; if (got != 6 || sent != 6) begin bad++; $display("FAIL bp_count: emitted=%0d accepted=%0d exp=6", got, sent); end
    repeat (3) begin
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL bp_extra: got=%b exp=0", seen); end
  endtask

  task automatic fill_pipe(input logic [1:0] sew, input logic [31:0] base);
    int sent = 0;
    int cyc  = 0;
    logic acc;
    out_ready_i = 1'b0; op_i = 2'd0; sew_i = sew; shift_i = '0;
    while (sent < P && cyc < 20) begin
      in_valid_i = 1'b1; a_i = base + sent;
      #1;
      acc = in_ready_o;
      @(posedge clk_i); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    fill_pipe(2'd2, 32'hAAAA_0000);
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL flush_prefill: got=%b exp=1", out_valid_o); end
    flush_i = 1'b1; in_valid_i = 1'b1; a_i = 32'hBBBB_BBBB;
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid: got=%b exp=0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got=%b exp=1", in_ready_o); end
    out_ready_i = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ghost: got=%b exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    fill_pipe(2'd3, 32'hCAFE_F000);
    total++; if (out_valid_o !== 1'b1 || illegal_o !== 1'b1) begin
      bad++; $display("FAIL rst_prefill: valid=%b illegal=%b exp 1 1", out_valid_o, illegal_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got=%b exp=0", out_valid_o); end
    total++; if (result_o !== 32'h0) begin bad++; $display("FAIL rst_mid_result: got=%h exp=0", result_o); end
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL rst_mid_illegal: got=%b exp=0", illegal_o); end
    @(negedge clk_i); rst_ni = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got=%b exp=1", in_ready_o); end
    repeat (5) begin
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_ghost: got=%b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single("e32_sra",     2'd2, 2'd2, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 1'b0);
    test_single("e8_sll",      2'd0, 2'd0, 32'h0102_0304, 32'h0101_0109, 32'h0204_0608, 1'b0);
    test_single("e8_srl",      2'd1, 2'd0, 32'h0102_0304, 32'h0101_0101, 32'h0001_0102, 1'b0);
    test_single("e8_sra",      2'd2, 2'd0, 32'h80F0_7F01, 32'h0704_0301, 32'hFFFF_0F00, 1'b0);
    test_single("e8_ror_wrap", 2'd3, 2'd0, 32'h8101_7F80, 32'h0808_0808, 32'h8101_7F80, 1'b0);
    test_single("e16_ror",     2'd3, 2'd1, 32'h1234_8001, 32'h0004_0001, 32'h4123_C000, 1'b0);
    test_single("e16_sra",     2'd2, 2'd1, 32'h8000_7FFF, 32'h000F_000F, 32'hFFFF_0000, 1'b0);
    test_single("e32_ror_msk", 2'd3, 2'd2, 32'h0000_0001, 32'h0000_0021, 32'h8000_0000, 1'b0);
    test_single("e32_sh0",     2'd1, 2'd2, 32'hA5A5_5A5A, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0);
    test_single("rsvd",        2'd0, 2'd3, 32'hDEAD_BEEF, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1);
    test_single("after_rsvd",  2'd0, 2'd2, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0);
    test_back_to_back();
    test_flush();
    test_single("post_flush",  2'd1, 2'd1, 32'h00F0_F000, 32'h0004_0008, 32'h000F_00F0, 1'b0);
    test_reset_mid();
    test_single("post_reset",  2'd0, 2'd2, 32'h0000_00FF, 32'h0000_0008, 32'h0000_FF00, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
